// File: rtl/sdram_write_if.sv
// Handshake, wFIFO and SDRAM-pin bundle between the write engine (slave) and the controller (master).
// The trigger, refresh and grant inputs are plain levels; the engine waits in its request state until wr_en.
interface sdram_write_if #(
  parameter int ADDR_BITS = 12,
  parameter int BA_BITS   = 2,
  parameter int DQ_BITS   = 16
);
  logic                 wr_trig;
  logic                 aref_req;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [7:0]           wfifo_data;
  logic                 wr_req;
  logic [3:0]           wr_cmd;
  logic [ADDR_BITS-1:0] addr_out;
  logic [BA_BITS-1:0]   ba_out;
  logic [DQ_BITS-1:0]   data_out;
  logic                 dq_oe;
  logic                 wfifo_rd_en;
  logic                 go_aref;
  logic                 wr_done_all;

  modport slave (
    input  wr_trig, aref_req, wr_en, wr_addr, wfifo_data,
    output wr_req, wr_cmd, addr_out, ba_out, data_out, dq_oe, wfifo_rd_en, go_aref, wr_done_all
  );

  modport master (
    output wr_trig, aref_req, wr_en, wr_addr, wfifo_data,
    input  wr_req, wr_cmd, addr_out, ba_out, data_out, dq_oe, wfifo_rd_en, go_aref, wr_done_all
  );
endinterface

// File: rtl/sdram_write.sv
// SDR SDRAM burst-write engine: ACT, back-to-back 4-beat WRITEs from the wFIFO, PRE, over ROW_MAX+1 rows.
// First WRITE lands T_RCD+1 cycles after ACT; stalls in REQ until wr_en and yields to refresh at burst ends.
module sdram_write #(
  parameter int ADDR_BITS    = 12,
  parameter int BA_BITS      = 2,
  parameter int DQ_BITS      = 16,
  parameter int ROW_BITS     = 12,
  parameter int T_RCD        = 3,
  parameter int T_WR         = 2,
  parameter int T_RP         = 3,
  parameter int COL_ADDR_MAX = 7,
  parameter int ROW_MAX      = 1
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  sdram_write_if.slave bus
);

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;

  localparam int COL_W = $clog2(COL_ADDR_MAX + 1);
  localparam int CC_W  = (COL_W > 2) ? COL_W - 2 : 1;
  localparam int ACT_W = $clog2(T_RCD + 2);
  localparam int BRK_W = $clog2(T_WR + T_RP + 2);

  localparam logic [ACT_W-1:0]     ACT_LAST = ACT_W'(T_RCD);
  localparam logic [BRK_W-1:0]     PRE_AT   = BRK_W'(T_WR);
  localparam logic [BRK_W-1:0]     PRE_LAST = BRK_W'(T_WR + T_RP);
  localparam logic [CC_W+1:0]      COL_LAST = (CC_W + 2)'(COL_ADDR_MAX);
  localparam logic [ROW_BITS-1:0]  ROW_LAST = ROW_BITS'(ROW_MAX);
  localparam logic [ADDR_BITS-1:0] ADDR_ALL = ADDR_BITS'(1 << 10);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_ACT   = 3'd2,
    S_WRITE = 3'd3,
    S_PRE   = 3'd4
  } state_t;

  state_t              state_q;
  logic [ACT_W-1:0]    act_cnt_q;
  logic [1:0]          burst_cnt_q;
  logic [BRK_W-1:0]    break_cnt_q;
  logic [CC_W-1:0]     col_cnt_q;
  logic [ROW_BITS-1:0] row_cnt_q;
  logic [ROW_BITS-1:0] addr_row_q;
  logic                aref_pend_q;
  logic                row_end_q;

  logic                 act_done;
  logic                 burst_end;
  logic                 col_last;
  logic                 leave_write;
  logic                 pre_done;
  logic                 job_done;
  logic                 aref_go;
  logic [ROW_BITS-1:0]  row_addr;
  logic [3:0]           cmd;
  logic [ADDR_BITS-1:0] addr;

  assign act_done    = (state_q == S_ACT) && (act_cnt_q == ACT_LAST);
  assign burst_end   = (state_q == S_WRITE) && (burst_cnt_q == 2'd3);
  assign col_last    = ({col_cnt_q, burst_cnt_q} == COL_LAST);
  assign leave_write = burst_end && (col_last || aref_pend_q);
  assign pre_done    = (state_q == S_PRE) && (break_cnt_q == PRE_LAST);
  // Finishing the last row wins over a refresh that arrived during its PRE:
  // there is no column left to resume, so the bus is simply handed back.
  assign job_done    = pre_done && row_end_q && (row_cnt_q == ROW_LAST);
  assign aref_go     = pre_done && aref_pend_q && !job_done;
  assign row_addr    = addr_row_q + row_cnt_q;

  always_comb begin
    cmd  = CMD_NOP;
    addr = '0;
    if (state_q == S_ACT && act_cnt_q == '0) begin
      cmd  = CMD_ACT;
      addr = ADDR_BITS'(row_addr);
    end else if (state_q == S_WRITE && burst_cnt_q == 2'd0) begin
      cmd  = CMD_WRITE;
      addr = ADDR_BITS'({col_cnt_q, 2'b00});
    end else if (state_q == S_PRE && break_cnt_q == PRE_AT) begin
      cmd  = CMD_PRE;
      addr = ADDR_ALL;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      act_cnt_q   <= '0;
      burst_cnt_q <= '0;
      break_cnt_q <= '0;
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      addr_row_q  <= '0;
      aref_pend_q <= 1'b0;
      row_end_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE || aref_go) begin
        aref_pend_q <= 1'b0;
      end else if (bus.aref_req) begin
        aref_pend_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.wr_trig) begin
            addr_row_q <= ROW_BITS'(bus.wr_addr);
            row_cnt_q  <= '0;
            col_cnt_q  <= '0;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.wr_en) begin
            act_cnt_q <= '0;
            state_q   <= S_ACT;
          end
        end
        S_ACT: begin
          if (act_done) begin
            burst_cnt_q <= '0;
            state_q     <= S_WRITE;
          end else begin
            act_cnt_q <= act_cnt_q + ACT_W'(1);
          end
        end
        S_WRITE: begin
          burst_cnt_q <= burst_cnt_q + 2'd1;
          if (burst_end) begin
            col_cnt_q <= col_cnt_q + CC_W'(1);
            if (leave_write) begin
              row_end_q   <= col_last;
              break_cnt_q <= '0;
              state_q     <= S_PRE;
            end
          end
        end
        S_PRE: begin
          if (pre_done) begin
            if (job_done) begin
              state_q <= S_IDLE;
            end else begin
              if (row_end_q) begin
                row_cnt_q <= row_cnt_q + ROW_BITS'(1);
                col_cnt_q <= '0;
              end
              act_cnt_q <= '0;
              state_q   <= aref_go ? S_REQ : S_ACT;
            end
          end else begin
            break_cnt_q <= break_cnt_q + BRK_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.wr_req      = (state_q == S_REQ);
  assign bus.wr_cmd      = cmd;
  assign bus.addr_out    = addr;
  assign bus.ba_out      = '0;
  assign bus.data_out    = {{(DQ_BITS - 8){1'b0}}, bus.wfifo_data};
  assign bus.dq_oe       = (state_q == S_WRITE);
  // Pops run one cycle ahead of the beats, so the final beat of a segment pops nothing.
  assign bus.wfifo_rd_en = act_done || ((state_q == S_WRITE) && !leave_write);
  assign bus.go_aref     = aref_go;
  assign bus.wr_done_all = job_done;

endmodule

// File: tb/tb_sdram_write.sv
// Randomised directed jobs for sdram_write, checked against a command/beat timeline built from the write rules.
module tb_sdram_write;
  localparam int T_RCD        = 3;
  localparam int T_WR         = 2;
  localparam int T_RP         = 3;
  localparam int COL_ADDR_MAX = 7;
  localparam int ROW_MAX      = 1;
  localparam int BURSTS       = (COL_ADDR_MAX + 1) / 4;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010;

  typedef struct {
    int          c;
    logic [3:0]  cmd;
    logic [11:0] addr;
  } cmd_ev_t;

  typedef struct {
    int          c;
    logic [15:0] d;
  } beat_ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  cmd_ev_t  obs_cmd[$];
  cmd_ev_t  exp_cmd[$];
  beat_ev_t obs_beat[$];
  int       exp_beat[$];
  int       obs_pop[$];
  int       obs_aref[$];
  int       obs_done[$];
  int       req_cycles;
  int       ba_bad;
  logic [7:0] fifo_mem[256];
  int       pop_idx = 0;
  int       base;

  sdram_write_if #(.ADDR_BITS(12), .BA_BITS(2), .DQ_BITS(16)) bus ();

  sdram_write #(
    .ADDR_BITS(12), .BA_BITS(2), .DQ_BITS(16), .ROW_BITS(12),
    .T_RCD(T_RCD), .T_WR(T_WR), .T_RP(T_RP),
    .COL_ADDR_MAX(COL_ADDR_MAX), .ROW_MAX(ROW_MAX)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor plus wFIFO model: a pop seen in cycle k presents the next byte in cycle k+1.
  initial begin
    cmd_ev_t  ce;
    beat_ev_t be;
    logic     pend;
    bus.wfifo_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.wr_cmd !== NOP) begin
          ce.c = cyc; ce.cmd = bus.wr_cmd; ce.addr = bus.addr_out;
          obs_cmd.push_back(ce);
        end
        if (bus.dq_oe) begin
          be.c = cyc; be.d = bus.data_out;
          obs_beat.push_back(be);
        end
        if (bus.wfifo_rd_en) obs_pop.push_back(cyc);
        if (bus.go_aref)     obs_aref.push_back(cyc);
        if (bus.wr_done_all) obs_done.push_back(cyc);
        if (bus.wr_req)      req_cycles++;
        if (bus.ba_out !== 2'b00) ba_bad++;
      end
      pend = rst_n && bus.wfifo_rd_en;
      @(posedge clk);
      #1;
      if (pend) begin
        bus.wfifo_data = fifo_mem[pop_idx];
        pop_idx = (pop_idx + 1) % 256;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic clear_logs();
    obs_cmd.delete(); exp_cmd.delete(); obs_beat.delete(); exp_beat.delete();
    obs_pop.delete(); obs_aref.delete(); obs_done.delete();
    req_cycles = 0;
    ba_bad     = 0;
  endtask

  // One bus tenure on a row: ACT at cycle a, nb bursts from column col0, then PRE. ex = exit cycle.
  task automatic add_seg(input int a, input logic [11:0] row, input int col0, input int nb, output int ex);
    cmd_ev_t e;
    int      w0;
    e.c = a; e.cmd = ACT; e.addr = row;
    exp_cmd.push_back(e);
    w0 = a + T_RCD + 1;
    for (int i = 0; i < nb; i++) begin
      e.c = w0 + 4 * i; e.cmd = WR; e.addr = 12'(col0 + 4 * i);
      exp_cmd.push_back(e);
      for (int j = 0; j < 4; j++) exp_beat.push_back(w0 + 4 * i + j);
    end
    e.c = w0 + 4 * nb - 1 + T_WR + 1; e.cmd = PRE; e.addr = 12'h400;
    exp_cmd.push_back(e);
    ex = w0 + 4 * nb + T_WR + T_RP;
  endtask

  task automatic start_job(input logic [11:0] r);
    clear_logs();
    base = pop_idx;
    bus.wr_addr = r;
    bus.wr_trig = 1'b1;
    tick();
    bus.wr_trig = 1'b0;
  endtask

  task automatic grant(input int d, output int a);
    repeat (d) tick();
    bus.wr_en = 1'b1;
    a = cyc + 1;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_pulse(input bit want_done, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (want_done ? (obs_done.size() > 0) : (obs_aref.size() > 0)) break;
      tick();
    end
    chk(want_done ? "done_wait" : "aref_wait",
        32'(want_done ? (obs_done.size() > 0) : (obs_aref.size() > 0)), 32'd1);
  endtask

  task automatic finish_job();
    wait_pulse(1'b1, 300);
    repeat (6) tick();
    chk("idle_req", 32'(bus.wr_req), 32'd0);
    chk("idle_cmd", 32'(bus.wr_cmd), 32'(NOP));
  endtask

  task automatic check_job(input int exp_req, input int exp_aref, input int exp_done);
    chk("cmd_count", obs_cmd.size(), exp_cmd.size());
    for (int i = 0; i < exp_cmd.size() && i < obs_cmd.size(); i++) begin
      chk($sformatf("cmd%0d_cycle", i), obs_cmd[i].c, exp_cmd[i].c);
      chk($sformatf("cmd%0d_code", i), 32'(obs_cmd[i].cmd), 32'(exp_cmd[i].cmd));
      chk($sformatf("cmd%0d_addr", i), 32'(obs_cmd[i].addr), 32'(exp_cmd[i].addr));
    end
    chk("beat_count", obs_beat.size(), exp_beat.size());
    for (int i = 0; i < exp_beat.size() && i < obs_beat.size(); i++) begin
      chk($sformatf("beat%0d_cycle", i), obs_beat[i].c, exp_beat[i]);
      chk($sformatf("beat%0d_data", i), 32'(obs_beat[i].d), {24'h0, fifo_mem[(base + i) % 256]});
    end
    chk("pop_count", obs_pop.size(), exp_beat.size());
    for (int i = 0; i < exp_beat.size() && i < obs_pop.size(); i++)
      chk($sformatf("pop%0d_cycle", i), obs_pop[i], exp_beat[i] - 1);
    chk("done_count", obs_done.size(), 1);
    if (obs_done.size() > 0) chk("done_cycle", obs_done[0], exp_done);
    chk("aref_count", obs_aref.size(), (exp_aref < 0) ? 0 : 1);
    if (exp_aref >= 0 && obs_aref.size() > 0) chk("aref_cycle", obs_aref[0], exp_aref);
    chk("req_cycles", req_cycles, exp_req);
    chk("ba_zero", ba_bad, 0);
  endtask

  initial begin
    logic [11:0] r;
    int d1, d2, a0, a1, e1, e2, e3, c;

    for (int i = 0; i < 256; i++) fifo_mem[i] = 8'($urandom);
    bus.wr_trig  = 1'b0;
    bus.aref_req = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = 12'h000;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_cmd",  32'(bus.wr_cmd), 32'(NOP));
    chk("rst_req",  32'(bus.wr_req), 32'd0);
    chk("rst_addr", 32'(bus.addr_out), 32'd0);
    chk("rst_oe",   32'(bus.dq_oe), 32'd0);
    chk("rst_pop",  32'(bus.wfifo_rd_en), 32'd0);
    chk("rst_aref", 32'(bus.go_aref), 32'd0);
    chk("rst_done", 32'(bus.wr_done_all), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Two full rows from a random start row, with a stray trigger during the first burst.
    r  = 12'($urandom);
    d1 = $urandom_range(0, 5);
    start_job(r);
    grant(d1, a0);
    add_seg(a0, r, 0, BURSTS, e1);
    add_seg(e1 + 1, r + 12'd1, 0, BURSTS, e2);
    tick_until(a0 + T_RCD + 2);
    bus.wr_addr = ~r;
    bus.wr_trig = 1'b1;
    tick();
    bus.wr_trig = 1'b0;
    finish_job();
    check_job(d1 + 1, -1, e2);

    // Top row wraps to row 0; grant withheld for 10 cycles.
    r = 12'hFFF;
    start_job(r);
    grant(10, a0);
    add_seg(a0, r, 0, BURSTS, e1);
    add_seg(e1 + 1, r + 12'd1, 0, BURSTS, e2);
    finish_job();
    check_job(11, -1, e2);

    // Refresh request somewhere between ACT and the third beat of the first burst.
    for (int k = 0; k < 3; k++) begin
      r  = 12'($urandom);
      d1 = $urandom_range(0, 3);
      d2 = $urandom_range(0, 6);
      start_job(r);
      grant(d1, a0);
      c = a0 + ((k == 0) ? 0 : int'($urandom_range(0, T_RCD + 3)));
      tick_until(c);
      bus.aref_req = 1'b1;
      tick();
      bus.aref_req = 1'b0;
      wait_pulse(1'b0, 100);
      grant(d2, a1);
      add_seg(a0, r, 0, 1, e1);
      add_seg(a1, r, 4, BURSTS - 1, e2);
      add_seg(e2 + 1, r + 12'd1, 0, BURSTS, e3);
      finish_job();
      check_job(d1 + d2 + 2, e1, e3);
    end

    // Reset during the second beat, then a fresh job from a new row.
    r = 12'($urandom);
    start_job(r);
    grant(0, a0);
    tick_until(a0 + T_RCD + 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_cmd",  32'(bus.wr_cmd), 32'(NOP));
    chk("midrst_req",  32'(bus.wr_req), 32'd0);
    chk("midrst_addr", 32'(bus.addr_out), 32'd0);
    chk("midrst_oe",   32'(bus.dq_oe), 32'd0);
    chk("midrst_pop",  32'(bus.wfifo_rd_en), 32'd0);
    chk("midrst_done", 32'(bus.wr_done_all), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    r  = 12'($urandom);
    d1 = $urandom_range(0, 4);
    start_job(r);
    grant(d1, a0);
    add_seg(a0, r, 0, BURSTS, e1);
    add_seg(e1 + 1, r + 12'd1, 0, BURSTS, e2);
    finish_job();
    check_job(d1 + 1, -1, e2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_write.md
# sdram_write

Burst-write engine for the SDR SDRAM controller. It is the write-direction counterpart of the controller's read engine. On a write trigger it requests the bus from the arbiter. Once granted, it performs ACTIVATE, then back-to-back 4-beat WRITE bursts without auto-precharge fed from the wFIFO, then PRECHARGE, across a configurable run of consecutive rows. It yields to AUTO-REFRESH at burst boundaries and later resumes at the next column.

## Interface
Parameters:
- ADDR_BITS, 12, SDRAM address width (A11..A0)
- BA_BITS, 2, bank address width
- DQ_BITS, 16, SDRAM data width
- ROW_BITS, 12, row address width
- T_RCD, 3, ACTIVATE-to-WRITE cycles
- T_WR, 2, last-data-to-PRECHARGE cycles
- T_RP, 3, PRECHARGE-to-next-command cycles
- COL_ADDR_MAX, 7, last column written per row; must equal 4k+3
- ROW_MAX, 1, number of rows minus 1

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- wr_trig  in  1  start a write job; sampled only in IDLE
- aref_req  in  1  refresh request from the refresh block
- wr_en  in  1  arbiter grant
- wr_addr  in  ADDR_BITS  start row; latched on wr_trig in IDLE
- wfifo_data  in  8  wFIFO read data, valid 1 cycle after wfifo_rd_en
- wr_req  out  1  bus request to the arbiter
- wr_cmd  out  4  {CS_n, RAS_n, CAS_n, WE_n}
- addr_out  out  ADDR_BITS  SDRAM address
- ba_out  out  BA_BITS  bank address, constant 0
- data_out  out  DQ_BITS  write data, {zeros, wfifo_data}
- dq_oe  out  1  DQ output enable
- wfifo_rd_en  out  1  wFIFO pop
- go_aref  out  1  one-cycle pulse: bus released for refresh
- wr_done_all  out  1  one-cycle pulse: job complete

## Operation
- Commands:
  - NOP = 0111
  - ACT = 0011
  - WRITE = 0100
  - PRE = 0010
- States: IDLE, REQ, ACT, WRITE, PRE (3-bit, registered).
- IDLE:
  - On wr_trig, latch addr_row=wr_addr, clear row_cnt and col_cnt, and go to REQ.
  - aref_req is ignored in IDLE.
- REQ:
  - wr_req=1 (combinational, state==REQ).
  - On wr_en, go to ACT.
- ACT:
  - act_cnt counts from 0.
  - ACT is issued at act_cnt==0 with addr_out=addr_row+row_cnt (ROW_BITS wrap).
  - act_done is asserted at act_cnt==T_RCD; the state then moves to WRITE.
- WRITE:
  - burst_cnt counts 0..3 and wraps.
  - WRITE is issued at burst_cnt==0 with addr_out={0, col_cnt, 2'b00}; A10=0.
  - Column address = {col_cnt, burst_cnt}.
  - col_cnt increments at burst_cnt==3.
- Burst end (burst_cnt==3):
  - If column == COL_ADDR_MAX, or aref_req_t=1, go to PRE.
  - Otherwise stay in WRITE.
- PRE:
  - break_cnt counts from 0.
  - Cycles 0..T_WR-1 issue NOP.
  - PRE is issued at break_cnt==T_WR with addr_out=12'h400 (A10=1, all banks).
  - pre_done is asserted at break_cnt==T_WR+T_RP.
- PRE exit:
  - Refresh pending: pulse go_aref, clear aref_req_t, go to REQ. row_cnt and col_cnt are held, so the job resumes at the next column of the same row.
  - Row complete and row_cnt==ROW_MAX: pulse wr_done_all and go to IDLE.
  - Row complete otherwise: increment row_cnt, clear col_cnt, and go to ACT directly, keeping the bus.
- aref_req_t:
  - Set by aref_req in any state except IDLE.
  - Cleared at go_aref and in IDLE.
  - A request arriving during ACT or PRE is served at the next burst end or PRE exit.
- dq_oe=1 exactly in WRITE.
- data_out={(DQ_BITS-8)'b0, wfifo_data}, combinational.
- wfifo_rd_en=1 when:
  - act_done, or
  - state==WRITE, except at a burst_cnt==3 cycle that leaves WRITE.
- This yields exactly one pop per beat, each 1 cycle ahead of the beat.
- A wr_trig outside IDLE is ignored.
- wr_cmd is NOP in all cycles not listed above.

## Timing
- Reset values: state=IDLE, wr_cmd=0111, all other outputs 0, all counters 0. Reset mid-job aborts immediately with no completion pulse.
- wr_trig at cycle n puts the engine in REQ at n+1.
- wr_en at cycle m puts the engine in ACT at m+1.
- ACT occupies T_RCD+1 cycles; the first WRITE is issued T_RCD+1 cycles after ACT.
- PRE occupies T_WR+T_RP+1 cycles. The PRE command is issued T_WR+1 cycles after the last data beat.
- go_aref and wr_done_all are high for the single PRE-exit cycle.
- Defaults, per row: 8 beats, 2 WRITE commands at columns 0 and 4.

## Test plan
- Single row:
  - Stimulus: ROW_MAX=0, wr_addr=12'h005, wr_trig, wr_en 2 cycles later.
  - Response: ACT addr 0x005; WRITEs at col 0 and 4; 8 wfifo_rd_en pulses; data_out equals FIFO bytes 0..7 on the dq_oe cycles; PRE addr 0x400 T_WR+1 cycles after the last beat; one wr_done_all pulse; back to IDLE.
- Two rows (defaults):
  - ACT 0x005, 8 beats, PRE, then ACT 0x006 without wr_req, 8 beats, PRE.
  - wr_done_all asserted only after the second PRE.
- Refresh mid-row:
  - Stimulus: aref_req pulse during the first burst.
  - Response: PRE after beat 3; go_aref pulse; REQ. After wr_en, ACT 0x005 again and WRITE resumes at col 4 with 4 more pops; total pops = 8.
- Delayed grant:
  - Stimulus: wr_en held low 10 cycles.
  - Response: wr_req=1 and wr_cmd=NOP for all 10 cycles; no pops.
- Reset:
  - Stimulus: sys_rst_n low during the second beat.
  - Response: outputs reset immediately.
  - A new wr_trig restarts at row wr_addr, col 0.
- Stray trigger:
  - Stimulus: wr_trig pulsed during WRITE.
  - Response: no effect; exactly one wr_done_all.
